// File: rtl/mini_alu_stack_core.sv
// MiniAlu execution core: 28-bit instruction fetch/execute with a parametrised
// datapath, a CALL/RET return stack, a HALT state and a pipeline-freeze input.
module mini_alu_stack_core #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_W       = 3
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               iStall,
  input  logic [27:0]                        iInstruction,
  output logic [IP_W-1:0]                    oIP,
  output logic [LED_W-1:0]                   oLed,
  output logic                               oStackErr,
  output logic                               oHalted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackLevel
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int NREG  = 1 << REG_ADDR_W;

  typedef enum logic [3:0] {
    opNop  = 4'h0, opAdd  = 4'h1, opSto  = 4'h2, opBle  = 4'h3,
    opBne  = 4'h4, opJmp  = 4'h5, opMul  = 4'h6, opCall = 4'h7,
    opRet  = 4'h8, opInc  = 4'h9, opAddi = 4'hA, opMuli = 4'hB,
    opLed  = 4'hC, opSub  = 4'hD, opRsvd = 4'hE, opHalt = 4'hF
  } opE;

  typedef enum logic {stRun, stHalted} stateE;

  stateE                  state;
  logic [27:0]            ir;
  logic [IP_W-1:0]        ipReg;
  logic [DATA_W-1:0]      regs [NREG];
  logic [IP_W-1:0]        stack [STACK_DEPTH];
  logic [LVL_W-1:0]       stackLevel;

  opE                     op;
  logic [REG_ADDR_W-1:0]  dstAddr, s1Addr, s0Addr;
  logic [DATA_W-1:0]      r1, r0;
  logic [SP_W-1:0]        pushIdx, topIdx;
  logic                   exec, stackFull, stackEmpty;

  logic                   takeBranch, wrEn, ledEn, doPush, doPop, stackFault, haltNow;
  logic [DATA_W-1:0]      wrData;
  logic [IP_W-1:0]        target;

  assign op         = opE'(ir[27:24]);
  assign dstAddr    = ir[16 +: REG_ADDR_W];
  assign s1Addr     = ir[8 +: REG_ADDR_W];
  assign s0Addr     = ir[0 +: REG_ADDR_W];
  assign r1         = regs[s1Addr];
  assign r0         = regs[s0Addr];
  assign pushIdx    = SP_W'(stackLevel);
  assign topIdx     = SP_W'(stackLevel - 1'b1);
  assign stackFull  = (stackLevel == LVL_W'(STACK_DEPTH));
  assign stackEmpty = (stackLevel == '0);
  assign exec       = (state == stRun) && !iStall;

  always_comb begin
    takeBranch = 1'b0;
    wrEn       = 1'b0;
    ledEn      = 1'b0;
    doPush     = 1'b0;
    doPop      = 1'b0;
    stackFault = 1'b0;
    haltNow    = 1'b0;
    wrData     = '0;
    target     = IP_W'(ir[23:16]);
    if (exec) begin
      case (op)
        opAdd:  begin wrEn = 1'b1; wrData = r1 + r0; end
        opSto:  begin wrEn = 1'b1; wrData = DATA_W'(ir[15:0]); end
        opBle:  takeBranch = (r1 <= r0);
        opBne:  takeBranch = (r1 != r0);
        opJmp:  takeBranch = 1'b1;
        opMul:  begin wrEn = 1'b1; wrData = r1 * r0; end
        opCall: begin
          if (stackFull) stackFault = 1'b1;
          else begin doPush = 1'b1; takeBranch = 1'b1; end
        end
        opRet: begin
          if (stackEmpty) stackFault = 1'b1;
          else begin doPop = 1'b1; takeBranch = 1'b1; target = stack[topIdx]; end
        end
        opInc:  begin wrEn = 1'b1; wrData = r1 + 1'b1; end
        opAddi: begin wrEn = 1'b1; wrData = r1 + DATA_W'(ir[7:0]); end
        opMuli: begin wrEn = 1'b1; wrData = r1 * DATA_W'(ir[7:0]); end
        opLed:  ledEn = 1'b1;
        opSub:  begin wrEn = 1'b1; wrData = r1 - r0; end
        opHalt: haltNow = 1'b1;
        default: ;
      endcase
    end
  end

  assign oIP         = takeBranch ? target : ipReg;
  assign oHalted     = (state == stHalted);
  assign oStackLevel = stackLevel;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= stRun;
      ir         <= '0;
      ipReg      <= '0;
      regs       <= '{default: '0};
      stack      <= '{default: '0};
      stackLevel <= '0;
      oLed       <= '0;
      oStackErr  <= 1'b0;
    end else if (exec) begin
      // HALT freezes the fetch pointer at the address following the HALT.
      if (haltNow) begin
        state <= stHalted;
      end else begin
        ir    <= iInstruction;
        ipReg <= oIP + 1'b1;
      end
      if (wrEn)       regs[dstAddr]  <= wrData;
      if (ledEn)      oLed           <= r1[LED_W-1:0];
      if (doPush) begin
        stack[pushIdx] <= ipReg;
        stackLevel     <= stackLevel + 1'b1;
      end
      if (doPop)      stackLevel     <= stackLevel - 1'b1;
      if (stackFault) oStackErr      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mini_alu_stack_core.sv
// Bench for mini_alu_stack_core: directed programs plus random programs, all
// checked cycle by cycle against an instruction-level reference interpreter.
module tb_mini_alu_stack_core;

  localparam int DW    = 16;
  localparam int RAW   = 4;
  localparam int IPW   = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int unsigned DMOD = 65536;

  logic            Clock = 1'b0;
  logic            Reset;
  logic            iStall;
  logic [27:0]     iInstruction;
  logic [IPW-1:0]  oIP;
  logic [LW-1:0]   oLed;
  logic            oStackErr;
  logic            oHalted;
  logic [2:0]      oStackLevel;

  logic [27:0]     rom [256];

  assign iInstruction = (oIP < IPW'(256)) ? rom[oIP[7:0]] : 28'h0;

  always #5 Clock = ~Clock;

  mini_alu_stack_core #(
    .DATA_W(DW), .REG_ADDR_W(RAW), .IP_W(IPW), .STACK_DEPTH(DEPTH), .LED_W(LW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iInstruction(iInstruction),
    .oIP(oIP), .oLed(oLed), .oStackErr(oStackErr), .oHalted(oHalted),
    .oStackLevel(oStackLevel)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural reference state.
  int unsigned mRegs [16];
  logic [15:0] mStk [$];
  int unsigned mLed, mPc, mIpSeq;
  bit          mErr, mHalted, mIrValid;

  function automatic logic [27:0] fetch(input int unsigned a);
    return (a < 256) ? rom[a] : 28'h0;
  endfunction

  task automatic modelReset();
    foreach (mRegs[i]) mRegs[i] = 0;
    mStk.delete();
    mLed = 0; mPc = 0; mIpSeq = 0;
    mErr = 0; mHalted = 0; mIrValid = 0;
  endtask

  task automatic modelStep();
    logic [27:0] ins;
    int unsigned op, d, s1, s0, r1, r0, npc;
    if (mHalted) return;
    ins = fetch(mPc);
    op = ins[27:24]; d = ins[23:16]; s1 = ins[15:8]; s0 = ins[7:0];
    r1 = mRegs[s1 % 16];
    r0 = mRegs[s0 % 16];
    npc = (mPc + 1) % 65536;
    case (op)
      1:  mRegs[d % 16] = (r1 + r0) % DMOD;
      2:  mRegs[d % 16] = (s1 * 256 + s0) % DMOD;
      3:  if (r1 <= r0) npc = d;
      4:  if (r1 != r0) npc = d;
      5:  npc = d;
      6:  mRegs[d % 16] = (r1 * r0) % DMOD;
      7:  if (mStk.size() == DEPTH) mErr = 1;
          else begin mStk.push_back(16'((mPc + 1) % 65536)); npc = d; end
      8:  if (mStk.size() == 0) mErr = 1;
          else npc = mStk.pop_back();
      9:  mRegs[d % 16] = (r1 + 1) % DMOD;
      10: mRegs[d % 16] = (r1 + s0) % DMOD;
      11: mRegs[d % 16] = (r1 * s0) % DMOD;
      12: mLed = r1 % 8;
      13: mRegs[d % 16] = (r1 + DMOD - r0) % DMOD;
      15: mHalted = 1;
      default: ;
    endcase
    mPc = npc;
  endtask

  // One sample per cycle with the clock low; the model advances in step.
  task automatic runCycles(input int n, input int stallPct, input logic [31:0] stallMask);
    int unsigned expIp;
    bit stall;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      stall = ((i < 32) ? stallMask[i] : 1'b0) || ($urandom_range(99) < stallPct);
      iStall = stall;
      #1;
      checkEq("led", 32'(oLed), mLed);
      checkEq("stackErr", 32'(oStackErr), 32'(mErr));
      checkEq("stackLevel", 32'(oStackLevel), mStk.size());
      checkEq("halted", 32'(oHalted), 32'(mHalted));
      if (mHalted || stall) expIp = mIpSeq;
      else if (!mIrValid) begin expIp = mPc; mIrValid = 1; end
      else begin modelStep(); expIp = mPc; end
      checkEq("ip", 32'(oIP), expIp);
      if (!mHalted && !stall) mIpSeq = (expIp + 1) % 65536;
    end
    iStall = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, " ip"}, 32'(oIP), 0);
    checkEq({tag, " halted"}, 32'(oHalted), 0);
    checkEq({tag, " led"}, 32'(oLed), 0);
    checkEq({tag, " stackErr"}, 32'(oStackErr), 0);
    checkEq({tag, " stackLevel"}, 32'(oStackLevel), 0);
  endtask

  task automatic doReset();
    iStall = 1'b0;
    Reset  = 1'b0;
    @(posedge Clock);
    #1;
    checkResetOutputs("reset");
    modelReset();
    Reset = 1'b1;
  endtask

  task automatic clearRom();
    foreach (rom[i]) rom[i] = 28'h0;
  endtask

  task automatic randomRom();
    int unsigned op;
    foreach (rom[i]) begin
      op = $urandom_range(15);
      if (op == 15 && $urandom_range(9) != 0) op = 0;
      if (op == 3 || op == 4 || op == 5 || op == 7)
        rom[i] = {4'(op), 8'($urandom_range(63)), 8'($urandom_range(255)), 8'($urandom_range(255))};
      else
        rom[i] = {4'(op), 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255))};
    end
  endtask

  initial begin
    Reset  = 1'b0;
    iStall = 1'b0;

    // 5 - 3 shown on the LEDs
    clearRom();
    rom[0] = 28'h2_01_00_05;
    rom[1] = 28'h2_02_00_03;
    rom[2] = 28'hD_03_01_02;
    rom[3] = 28'hC_00_03_00;
    doReset();
    runCycles(6, 0, 32'h0);
    checkEq("sub led", 32'(oLed), 32'h2);

    // wrap-around of INC and SUB
    clearRom();
    rom[0] = 28'h2_01_FF_FF;
    rom[1] = 28'h9_02_01_00;
    rom[2] = 28'hD_04_00_01;
    rom[3] = 28'hC_00_02_00;
    rom[4] = 28'hC_00_04_00;
    doReset();
    runCycles(6, 0, 32'h0);
    checkEq("inc wrap led", 32'(oLed), 32'h0);
    runCycles(1, 0, 32'h0);
    checkEq("sub wrap led", 32'(oLed), 32'h1);

    // three nested calls, each returning
    clearRom();
    rom[0]  = 28'h7_0A_00_00;
    rom[1]  = 28'hF_00_00_00;
    rom[10] = 28'h7_14_00_00;
    rom[11] = 28'h8_00_00_00;
    rom[20] = 28'h7_1E_00_00;
    rom[21] = 28'h8_00_00_00;
    rom[30] = 28'h8_00_00_00;
    doReset();
    runCycles(10, 0, 32'h0);
    checkEq("nest halted", 32'(oHalted), 1);
    checkEq("nest level", 32'(oStackLevel), 0);
    checkEq("nest err", 32'(oStackErr), 0);
    checkEq("nest ip", 32'(oIP), 2);

    // fifth call overflows the stack
    clearRom();
    rom[0]  = 28'h7_0A_00_00;
    rom[10] = 28'h7_14_00_00;
    rom[20] = 28'h7_1E_00_00;
    rom[30] = 28'h7_28_00_00;
    rom[40] = 28'h7_32_00_00;
    rom[41] = 28'hF_00_00_00;
    doReset();
    runCycles(9, 0, 32'h0);
    checkEq("ovf err", 32'(oStackErr), 1);
    checkEq("ovf level", 32'(oStackLevel), 4);
    checkEq("ovf ip", 32'(oIP), 42);

    // return with an empty stack
    clearRom();
    rom[0] = 28'h8_00_00_00;
    rom[2] = 28'hF_00_00_00;
    doReset();
    runCycles(5, 0, 32'h0);
    checkEq("udf err", 32'(oStackErr), 1);
    checkEq("udf level", 32'(oStackLevel), 0);
    checkEq("udf ip", 32'(oIP), 3);

    // taken BNE held in IR across three stall cycles
    clearRom();
    rom[0]  = 28'h2_01_00_01;
    rom[1]  = 28'h4_14_01_00;
    rom[2]  = 28'hF_00_00_00;
    rom[20] = 28'hC_00_01_00;
    rom[21] = 28'hF_00_00_00;
    doReset();
    runCycles(10, 0, 32'h0000_001C);
    checkEq("stall led", 32'(oLed), 1);
    checkEq("stall halted", 32'(oHalted), 1);
    checkEq("stall ip", 32'(oIP), 22);

    // HALT at address 6, then asynchronous reset while halted
    clearRom();
    rom[0] = 28'h2_05_00_07;
    rom[1] = 28'hC_00_05_00;
    rom[2] = 28'h8_00_00_00;
    rom[6] = 28'hF_00_00_00;
    doReset();
    runCycles(10, 0, 32'h0);
    runCycles(4, 50, 32'h0);
    checkEq("halt halted", 32'(oHalted), 1);
    checkEq("halt ip", 32'(oIP), 7);
    checkEq("halt led", 32'(oLed), 7);
    checkEq("halt err", 32'(oStackErr), 1);
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    checkResetOutputs("async");

    // random programs with random stalls
    for (int p = 0; p < 20; p++) begin
      randomRom();
      doReset();
      runCycles(200, 20, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mini_alu_stack_core.md
# mini_alu_stack_core

Parametrised successor to the MiniAlu execution core. It fetches 28-bit instructions from an external combinational instruction ROM, decodes and executes them against an internal register file, and drives a LED register. Relative to MiniAlu it adds:
- configurable data width;
- a nested CALL/RET return stack with sticky error detection;
- a SUB opcode;
- a HALT state;
- a pipeline-freeze input so the video and PS/2 subsystems can hold the core.

## Interface
Parameters:
- DATA_W, 16, register/ALU width (8..32)
- REG_ADDR_W, 4, register file address bits; 2^REG_ADDR_W registers
- IP_W, 16, instruction pointer width (≥8)
- STACK_DEPTH, 4, return-stack entries (≥1)
- LED_W, 3, LED output width (≤DATA_W)

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- iStall  in  1  1 = freeze core this cycle
- iInstruction  in  28  ROM data for address oIP, same cycle (combinational ROM)
- oIP  out  IP_W  instruction fetch address
- oLed  out  LED_W  LED register
- oStackErr  out  1  sticky return-stack overflow/underflow flag
- oHalted  out  1  core is in HALTED state
- oStackLevel  out  $clog2(STACK_DEPTH+1)  current return-stack occupancy

## Operation
- **Instruction fields:**
  - [27:24] op
  - [23:16] dst
  - [15:8] s1
  - [7:0] s0
- **Register addressing:**
  - Register addresses use the low REG_ADDR_W bits of each field.
  - R1 = reg[s1], R0 = reg[s0]; registers are read combinationally at execute.
- **Pipeline:**
  - Fetch: IR captures iInstruction at each unstalled edge.
  - Execute: operates on IR.
  - State: IPreg holds the next sequential fetch address.
- **Fetch address:**
  - oIP = target when a branch is taken in execute this cycle; otherwise oIP = IPreg.
  - Each unstalled RUN edge: IPreg <= oIP+1 (mod 2^IP_W).
  - Branch target = dst zero-extended to IP_W, except RET.
- **Opcodes** (arithmetic is unsigned and truncated to DATA_W; write target is reg[dst]):
  - 0 NOP
  - 1 ADD: R1+R0
  - 2 STO: {s1,s0} zero-extended or truncated to DATA_W
  - 3 BLE: branch if R1<=R0
  - 4 BNE: branch if R1!=R0
  - 5 JMP: always branch
  - 6 MUL: low DATA_W bits of R1*R0
  - 7 CALL: push IPreg, branch
  - 8 RET: branch to top of stack, pop
  - 9 INC: R1+1
  - A ADDi: R1+zext(s0)
  - B MULi: low DATA_W bits of R1*zext(s0)
  - C LED: oLed <= R1[LED_W-1:0]
  - D SUB: R1−R0, wraps modulo 2^DATA_W
  - E NOP (reserved)
  - F HALT
- **Return stack:**
  - LIFO of IP_W-bit entries; oStackLevel counts 0..STACK_DEPTH.
  - CALL while level==STACK_DEPTH: no push, no branch (executes as NOP), oStackErr <= 1.
  - RET while level==0: no pop, no branch, oStackErr <= 1.
  - oStackErr clears only on reset.
- **States:**
  - RUN:
    - iStall=0: normal execution.
    - iStall=1: IPreg, IR, register file, stack, oLed and state all hold; no branch is evaluated; oIP = IPreg.
    - Execute of HALT with iStall=0 → HALTED.
  - HALTED:
    - oHalted=1; oIP = IPreg frozen; IR, registers, stack and oLed hold; iStall is ignored.
    - Exit only by reset.
- **Reset** (asynchronous; any time, including mid-branch or while HALTED):
  - IPreg=0, IR=NOP, all registers=0, stack empty, oLed=0, oStackErr=0, state=RUN.
  - While Reset=0: oIP=0, oHalted=0, oStackLevel=0.

## Timing
- After Reset rises: edge 1 captures instr[0] (IPreg→1); edge 2 completes execution of instr[0].
- Each instruction retires one cycle after its fetch. There are no bubbles and no delay slots: the branch target is fetched in the same cycle the branch executes.
- Register write lands at the execute edge; the next instruction reads the new value (no hazard, single execute stage).
- CALL at address a pushes a+1. RET returns to a+1, which is fetched in the cycle RET executes.
- oLed updates at the LED execute edge. oStackErr sets at the offending execute edge.
- iStall is sampled every edge; one stall cycle delays all subsequent retirement by exactly one cycle.

## Test plan
- Reset, then program STO r1,0x0005; STO r2,0x0003; SUB r3,r1,r2; LED r3 → oLed=3'b010 two cycles after the LED instruction is fetched; oIP sequence 0,1,2,3,4.
- DATA_W=16: STO r1,0xFFFF; INC r2,r1; SUB r4,r0,r1 → r2=0x0000, r4=0x0001 (wrap).
- Nested CALL 3 deep with STACK_DEPTH=4, each callee ending in RET → oStackLevel 1,2,3,2,1,0; execution resumes at each CALL address+1; oStackErr=0.
- Five nested CALLs with STACK_DEPTH=4 → 5th executes as NOP, oStackErr=1, level stays 4; RET at level 0 in a separate run → oStackErr=1, oIP continues sequentially.
- iStall=1 for 3 cycles while IR holds a BNE that is taken → oIP=IPreg held for 3 cycles, branch taken on the first unstalled cycle, total latency +3.
- HALT at address 6 → oHalted=1 from the execute edge, oIP frozen at 7; assert Reset=0 mid-HALT → oIP=0, oHalted=0, oLed=0, oStackErr=0 immediately (asynchronous).
